// File: rtl/fetch_pkg.sv
// Shared types and defaults for the prefetching fetch unit.
package fetch_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;
  localparam int          DEF_AW           = 16;
  localparam int          DEF_DW           = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_e;

  // Queue entry layout at the default widths; the top mirrors it at AW/DW.
  typedef struct packed {
    logic [DEF_DW-1:0] inst;
    logic [DEF_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; storage is unreset, only pointers/count are.
module fetch_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch unit: fetch PC, single-outstanding memory read, DEPTH-entry
// instruction queue, and redirect handling that can abandon an in-flight read.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] inst_npc
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] pc;
  } entry_t;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          push, pop;
  logic [CW-1:0] count, count_after_pop, count_after_push;
  entry_t        head, wdata;

  // A flushed head is never counted as consumed.
  assign pop              = inst_valid && inst_ready && !redirect;
  assign count_after_pop  = count - CW'(pop);
  assign count_after_push = count_after_pop + CW'(1);
  assign wdata            = '{inst: mem_rdata, pc: fpc_q};

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d   = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (count_after_pop < FULL) begin
          addr_d  = fpc_q;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_d = redirect_pc;
          if (mem_ack) addr_d = redirect_pc;
          else         state_d = DROP;
        end else if (mem_ack) begin
          push  = 1'b1;
          fpc_d = fpc_q + AW'(1);
          if (count_after_push < FULL) begin
            addr_d = fpc_q + AW'(1);
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // mem_addr stays on the abandoned read until its ack is swallowed.
        if (redirect) fpc_d = redirect_pc;
        if (mem_ack) begin
          addr_d  = redirect ? redirect_pc : fpc_q;
          state_d = REQ;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_npc   = head.pc + AW'(1);

endmodule
